memory_unit: RTL and testbench
==============================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of byte locations; always a power of two, at most 65536.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port mem_ce, input, 1 bit: chip enable; all other mem_* controls are ignored while it is low.
REQ-005 SHALL have port mem_r, input, 1 bit: read request, address phase.
REQ-006 SHALL have port mem_oe, input, 1 bit: output enable, data phase of a read.
REQ-007 SHALL have port mem_w, input, 1 bit: write strobe.
REQ-008 SHALL have port mem_rst, input, 1 bit: start a clear of the whole array.
REQ-009 SHALL have port addr_bus_in, input, 16 bits: byte address.
REQ-010 SHALL have port data_bus_in, input, 8 bits: write data.
REQ-011 SHALL have port data_bus_out, output, 8 bits: read data; 8'bz whenever this block is not driving.
REQ-012 SHALL have port busy, output, 1 bit: high while a clear is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED and CLEAR.
REQ-014 Command decode at posedge, with mem_ce=1 and state not CLEAR, priority mem_rst > mem_w > mem_r.
REQ-015 Write command: mem[addr_bus_in] <= data_bus_in in the same edge (1-cycle write); next state IDLE.
REQ-016 Read command: latch the array word into rd_lat and go to ARMED.
- Out-of-range address (addr_bus_in >= DEPTH): rd_lat = 8'hFF.
- Read latency: data is available in the cycle following the mem_r cycle.
REQ-017 data_bus_out = rd_lat combinationally when state==ARMED && mem_ce && mem_oe; otherwise 8'bz.
REQ-018 ARMED SHALL return to IDLE at the next posedge unless a new read or write command is decoded there; the new command is then executed as in REQ-015/016.
REQ-019 Out-of-range writes SHALL be dropped without error; array unchanged.
REQ-020 Clear command: enter CLEAR, busy=1 (registered, visible the cycle after the command), clr_cnt=0.
- Each posedge in CLEAR writes mem[clr_cnt] <= 8'h00 and increments clr_cnt.
- Leave CLEAR to IDLE on the edge that writes DEPTH-1; busy=0 from that edge.
- A clear therefore takes exactly DEPTH cycles.
REQ-021 While in CLEAR, every mem_* input (including a new mem_rst) SHALL be ignored and data_bus_out SHALL be 8'bz.
REQ-022 mem_oe without a preceding read (state IDLE) SHALL leave data_bus_out at 8'bz.
REQ-023 mem_oe and mem_w together: the write wins, and the bus stays high-Z if the state is not ARMED.
REQ-024 Address compare SHALL use the full 16 bits; the array is indexed by addr_bus_in[log2(DEPTH)-1:0].

Reset
REQ-025 On rst_n=0, immediately: state=IDLE, busy=0, clr_cnt=0, rd_lat=8'h00, data_bus_out=8'bz.
REQ-026 Array contents SHALL NOT be reset by rst_n; only mem_rst clears them.
REQ-027 rst_n asserted mid-clear SHALL abort the clear.
- Locations already cleared stay 0; the rest keep old values.
- After rst_n=1 the block accepts commands on the first posedge.

Verification
REQ-028 Write then read:
- Stimulus: mem_ce&mem_w, addr 16'h0010, data 8'hA5; then mem_ce&mem_r at 16'h0010; then mem_ce&mem_oe.
- Response: data_bus_out=8'hA5 in the oe cycle only, and 8'bz in the cycles before and after.
REQ-029 Fetch-style back-to-back:
- Stimulus: mem_r at addr N, then mem_oe, repeated for N=0..3 with preloaded 8'h11,22,33,44.
- Response: bus shows each value in its oe cycle.
REQ-030 Out of range:
- Stimulus: write 8'h5A to 16'h0400 with DEPTH=1024, then read 16'h0400 and 16'h0000.
- Response: reads return 8'hFF and the original mem[0].
REQ-031 Clear:
- Stimulus: fill all bytes with 8'hFF, pulse mem_ce&mem_rst, and issue writes during busy.
- Response: busy high exactly 1024 cycles, writes ignored, all bytes read 8'h00 afterwards.
REQ-032 Reset mid-clear:
- Stimulus: rst_n low at clear cycle 100.
- Response: busy=0 at once; mem[0..99]=8'h00; mem[100..1023]=8'hFF.
REQ-033 Priority:
- Stimulus: mem_ce with mem_w and mem_r both high, addr 16'h0020, data 8'h3C.
- Response: byte is written and state stays IDLE; a following mem_oe gives 8'bz.

Source files
------------

// File: rtl/memory_unit.sv
// Byte-wide single-port memory with a registered read latch, output-enable data
// phase and a DEPTH-cycle hardware clear sequencer.
module memory_unit #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ce,
    input  logic        mem_r,
    input  logic        mem_oe,
    input  logic        mem_w,
    input  logic        mem_rst,
    input  logic [15:0] addr_bus_in,
    input  logic [7:0]  data_bus_in,
    output logic [7:0]  data_bus_out,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [7:0]    rd_lat;
    logic [7:0]    mem [DEPTH];

    logic          in_range;
    logic [AW-1:0] idx;
    logic          cmd_ok;
    logic          clr_last;

    // Range check uses all 16 address bits so high addresses never alias.
    assign in_range = ({16'h0000, addr_bus_in} < 32'(DEPTH));
    assign idx      = addr_bus_in[AW-1:0];
    assign cmd_ok   = mem_ce && (state != CLEAR);
    assign clr_last = (clr_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
            rd_lat  <= 8'h00;
        end else if (cmd_ok && mem_rst) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
        end else if (cmd_ok && mem_w) begin
            state <= IDLE;
        end else if (cmd_ok && mem_r) begin
            rd_lat <= in_range ? mem[idx] : 8'hFF;
            state  <= ARMED;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_last) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            state <= IDLE;
        end
    end

    // Array has no reset; rst_n only gates writes so an aborted clear stops at once.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[clr_cnt] <= 8'h00;
            else if (mem_ce && !mem_rst && mem_w && in_range)
                mem[idx] <= data_bus_in;
        end
    end

    assign data_bus_out = (state == ARMED && mem_ce && mem_oe) ? rd_lat : 8'bz;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed vector table, clear / reset-abort
// sequences, and randomized traffic against a byte-array reference model.
module tb_memory_unit;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ce = 0, mem_r = 0, mem_oe = 0, mem_w = 0, mem_rst = 0;
    logic [15:0] addr_bus_in = '0;
    logic [7:0]  data_bus_in = '0;
    logic [7:0]  data_bus_out;
    logic        busy;

    memory_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ce(mem_ce), .mem_r(mem_r), .mem_oe(mem_oe),
        .mem_w(mem_w), .mem_rst(mem_rst), .addr_bus_in(addr_bus_in),
        .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] bus_s;
    logic       busy_s;
    logic [7:0] ref_mem [DEPTH];

    typedef struct {
        logic        ce, r, oe, w, rst;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive, sample mid-cycle, cross the posedge.
    task automatic step(input logic ce, r, oe, w, rst, input logic [15:0] a, input logic [7:0] d);
        mem_ce = ce; mem_r = r; mem_oe = oe; mem_w = w; mem_rst = rst;
        addr_bus_in = a; data_bus_in = d;
        @(negedge clk);
        bus_s  = data_bus_out;
        busy_s = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 16'h0, 8'h0);
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        step(1, 1, 0, 0, 0, a, 8'h0);
        step(1, 0, 1, 0, 0, a, 8'h0);
        v = bus_s;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0, 1, 0, 16'(i), v);
            ref_mem[i] = v;
        end
    endtask

    // Compare whole array to the model; one comparison per sweep.
    task automatic sweep(input string nm);
        int bad = 0;
        logic [7:0] v, first_act = 8'h00, first_exp = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            rd(16'(i), v);
            if (v !== ref_mem[i]) begin
                if (bad == 0) begin first_act = v; first_exp = ref_mem[i]; end
                bad++;
            end
        end
        chk(nm, (bad == 0) ? ref_mem[0] : first_act, (bad == 0) ? ref_mem[0] : first_exp);
        if (bad != 0) $display("  %s: %0d bytes differ", nm, bad);
    endtask

    function automatic void add(input logic ce, r, oe, w, rst, input logic [15:0] a,
                                input logic [7:0] d, input logic [7:0] exp);
        vec_t v;
        v.ce = ce; v.r = r; v.oe = oe; v.w = w; v.rst = rst; v.a = a; v.d = d; v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] z = 8'bz;
        logic [7:0] v;
        int cnt, zbad;
        logic       armed;
        logic [7:0] lat, exp;

        // Reset state, with ce/oe high to confirm the bus is released.
        mem_ce = 1; mem_oe = 1;
        #3;
        chk("reset_busy", {7'b0, busy}, 8'h00);
        chk("reset_bus", data_bus_out, z);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Write/read, fetch, out-of-range, priority, oe corner cases.
        add(1,0,0,1,0, 16'h0010, 8'hA5, z);
        add(1,1,0,0,0, 16'h0010, 8'h00, z);
        add(1,0,1,0,0, 16'h0010, 8'h00, 8'hA5);
        add(0,0,0,0,0, 16'h0000, 8'h00, z);
        add(1,0,0,1,0, 16'h0000, 8'h11, z);
        add(1,0,0,1,0, 16'h0001, 8'h22, z);
        add(1,0,0,1,0, 16'h0002, 8'h33, z);
        add(1,0,0,1,0, 16'h0003, 8'h44, z);
        for (int n = 0; n < 4; n++) begin
            add(1,1,0,0,0, 16'(n), 8'h00, z);
            add(1,0,1,0,0, 16'(n), 8'h00, 8'(8'h11 * (n + 1)));
        end
        add(1,0,0,1,0, 16'h0400, 8'h5A, z);
        add(1,1,0,0,0, 16'h0400, 8'h00, z);
        add(1,0,1,0,0, 16'h0400, 8'h00, 8'hFF);
        add(1,1,0,0,0, 16'h0000, 8'h00, z);
        add(1,0,1,0,0, 16'h0000, 8'h00, 8'h11);
        add(1,1,0,1,0, 16'h0020, 8'h3C, z);
        add(1,0,1,0,0, 16'h0020, 8'h00, z);
        add(1,1,0,0,0, 16'h0020, 8'h00, z);
        add(1,0,1,0,0, 16'h0020, 8'h00, 8'h3C);
        add(1,0,0,1,0, 16'h0410, 8'h77, z);
        add(1,1,0,0,0, 16'h0010, 8'h00, z);
        add(0,0,1,0,0, 16'h0010, 8'h00, z);
        add(1,0,1,0,0, 16'h0010, 8'h00, z);
        add(1,1,0,0,0, 16'h0010, 8'h00, z);
        add(1,0,1,1,0, 16'h0011, 8'h99, 8'hA5);
        add(1,0,1,0,0, 16'h0011, 8'h00, z);
        add(1,1,0,0,0, 16'h0011, 8'h00, z);
        add(1,0,1,0,0, 16'h0011, 8'h00, 8'h99);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ce, tbl[i].r, tbl[i].oe, tbl[i].w, tbl[i].rst, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d", i), bus_s, tbl[i].exp);
        end

        // Full clear while hammering the inputs.
        fill(8'hFF);
        step(1, 0, 0, 0, 1, 16'h0, 8'h0);
        chk("clr_cmd_busy", {7'b0, busy_s}, 8'h00);
        cnt = 0; zbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, i[0], 1, 1, (i < DEPTH - 24), 16'(i), 8'h55);
            if (busy_s === 1'b1) cnt++;
            if (bus_s !== z) zbad++;
        end
        idle();
        chk("clr_busy_cycles", 8'(cnt >> 2), 8'(DEPTH >> 2));
        chk("clr_busy_low_after", {7'b0, busy_s}, 8'h00);
        chk("clr_bus_z_count", 8'(zbad), 8'h00);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        sweep("clr_all_zero");

        // Abort a clear after 100 cleared bytes.
        fill(8'hFF);
        step(1, 0, 0, 0, 1, 16'h0, 8'h0);
        for (int i = 0; i < 100; i++) idle();
        chk("abort_busy_before", {7'b0, busy_s}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_now", {7'b0, busy}, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        #1;
        rd(16'h0000, v);
        chk("abort_first_cmd", v, 8'h00);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 100) ? 8'h00 : 8'hFF;
        sweep("abort_contents");

        // Randomized traffic against the model.
        idle();
        armed = 1'b0; lat = 8'h00;
        for (int i = 0; i < 600; i++) begin
            logic ce, r, oe, w;
            logic [15:0] a;
            logic [7:0] d;
            ce = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 1);
            oe = $urandom_range(0, 1);
            w  = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 16'($urandom_range(DEPTH, 16'hFFFF));
                1:       a = 16'($urandom_range(0, DEPTH - 1));
                default: a = 16'($urandom_range(0, 15));
            endcase
            exp = (armed && ce && oe) ? lat : 8'bz;
            step(ce, r, oe, w, 0, a, d);
            chk($sformatf("rand%0d", i), bus_s, exp);
            armed = 1'b0;
            if (ce && w) begin
                if (a < DEPTH) ref_mem[a] = d;
            end else if (ce && r) begin
                lat = (a < DEPTH) ? ref_mem[a] : 8'hFF;
                armed = 1'b1;
            end
        end
        idle();
        sweep("rand_final_contents");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
